// File: rtl/fairy_muldiv_unit.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide on a
// shared 2*WIDTH accumulator, with sign correction in a separate FIX cycle.
module fairy_muldiv_unit #(
   parameter int WIDTH    = 32,
   parameter bit FAST_MUL = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             div_zero_o
);

   localparam int            CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;
   logic               is_div_q, is_div_d;
   logic               sa_q, sa_d, sb_q, sb_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d, dzo_q, dzo_d;

   logic               a_sgn, b_sgn;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod_full;
   logic [WIDTH-1:0]   rem_mag, quo_mag, rem_fix, quo_fix, a_orig;

   always_comb begin
      a_sgn     = ~op_i[0] & a_i[WIDTH-1];
      b_sgn     = ~op_i[0] & b_i[WIDTH-1];
      a_mag     = a_sgn ? -a_i : a_i;
      b_mag     = b_sgn ? -b_i : b_i;
      // Multiplier sits in the low half and is shifted out as partial sums shift in.
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? ma_q : {WIDTH{1'b0}})};
      prod_full = {{WIDTH{1'b0}}, ma_q} * {{WIDTH{1'b0}}, mb_q};
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, mb_q};
      rem_mag   = acc_q[2*WIDTH-1:WIDTH];
      quo_mag   = acc_q[WIDTH-1:0];
      rem_fix   = sa_q ? -rem_mag : rem_mag;
      quo_fix   = (sa_q ^ sb_q) ? -quo_mag : quo_mag;
      a_orig    = sa_q ? -ma_q : ma_q;

      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      ma_d     = ma_q;
      mb_d     = mb_q;
      is_div_d = is_div_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dzo_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               ma_d     = a_mag;
               mb_d     = b_mag;
               is_div_d = op_i[1];
               sa_d     = a_sgn;
               sb_d     = b_sgn;
               dz_d     = (b_i == '0);
               acc_d    = {{WIDTH{1'b0}}, (op_i[1] ? a_mag : b_mag)};
               cnt_d    = (FAST_MUL && !op_i[1]) ? CNT_ONE : CNT_FULL;
               state_d  = ST_CALC;
            end
         end
         ST_CALC: begin
            if (FAST_MUL && !is_div_q) begin
               acc_d = prod_full;
            end else if (!is_div_q) begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end else if (!div_diff[WIDTH]) begin
               acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (is_div_q) begin
               acc_d = dz_q ? {a_orig, {WIDTH{1'b1}}} : {rem_fix, quo_fix};
            end else if (sa_q ^ sb_q) begin
               acc_d = -acc_q;
            end
            state_d = ST_DONE;
         end
         default: begin
            hi_d    = acc_q[2*WIDTH-1:WIDTH];
            lo_d    = acc_q[WIDTH-1:0];
            done_d  = 1'b1;
            dzo_d   = dz_q & is_div_q;
            state_d = ST_IDLE;
         end
      endcase

      if (flush_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
         dzo_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         ma_q     <= '0;
         mb_q     <= '0;
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dzo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         ma_q     <= ma_d;
         mb_q     <= mb_d;
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dzo_q    <= dzo_d;
      end
   end

   assign busy_o     = (state_q != ST_IDLE);
   assign done_o     = done_q;
   assign div_zero_o = dzo_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;

endmodule

// File: tb/tb_fairy_muldiv_unit.sv
// Self-checking bench: iterative and single-cycle-multiply instances share stimulus and are
// compared against an arithmetic reference model.
module tb_fairy_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset, start_i, flush_i;
   logic [1:0]   op_i;
   logic [W-1:0] a_i, b_i;

   logic         busy_m, done_m, dz_m, busy_f, done_f, dz_f;
   logic [W-1:0] hi_m, lo_m, hi_f, lo_f;

   logic [W-1:0] exp_hi_m, exp_lo_m, exp_hi_f, exp_lo_f;
   int           n_checks = 0;
   int           n_errors = 0;

   fairy_muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b0)) u_dut (
      .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
      .flush_i(flush_i), .busy_o(busy_m), .done_o(done_m), .hi_o(hi_m), .lo_o(lo_m),
      .div_zero_o(dz_m)
   );

   fairy_muldiv_unit #(.WIDTH(W), .FAST_MUL(1'b1)) u_fast (
      .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
      .flush_i(flush_i), .busy_o(busy_f), .done_o(done_f), .hi_o(hi_f), .lo_o(lo_f),
      .div_zero_o(dz_f)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Plain signed/unsigned arithmetic; SV division truncates toward zero and the
   // remainder follows the dividend, which is the required divide behaviour.
   function automatic void ref_model(input logic [1:0] op, input logic [W-1:0] a, b,
                                     output logic [W-1:0] hi, lo, output logic dz);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      hi = '0;
      lo = '0;
      if (op == 2'd0) begin
         p = sa * sb;
         hi = p[2*W-1:W]; lo = p[W-1:0];
      end else if (op == 2'd1) begin
         p = {32'd0, a} * {32'd0, b};
         hi = p[2*W-1:W]; lo = p[W-1:0];
      end else if (b == '0) begin
         dz = 1'b1; hi = a; lo = '1;
      end else if (op == 2'd2) begin
         q = sa / sb; r = sa % sb;
         hi = r[W-1:0]; lo = q[W-1:0];
      end else begin
         p = {32'd0, a} / {32'd0, b}; hi = a % b; lo = p[W-1:0];
      end
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, b, input string tag);
      logic [W-1:0] ehi, elo, ghi_m, glo_m, ghi_f, glo_f;
      logic         edz;
      int           lat_m, lat_f, nd_m, nd_f, nz_m, nz_f;
      ref_model(op, a, b, ehi, elo, edz);
      lat_m = -1; lat_f = -1; nd_m = 0; nd_f = 0; nz_m = 0; nz_f = 0;
      ghi_m = 'x; glo_m = 'x; ghi_f = 'x; glo_f = 'x;
      @(negedge clk);
      op_i = op; a_i = a; b_i = b; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      check({tag, " busy"}, 64'(busy_m), 64'd1);
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (c == 20) check({tag, " hold"}, {hi_m, lo_m}, {exp_hi_m, exp_lo_m});
         if (done_m) begin nd_m++; lat_m = c; ghi_m = hi_m; glo_m = lo_m; end
         if (done_f) begin nd_f++; lat_f = c; ghi_f = hi_f; glo_f = lo_f; end
         if (dz_m) nz_m++;
         if (dz_f) nz_f++;
      end
      check({tag, " latency"}, 64'(lat_m), 64'd34);
      check({tag, " done count"}, 64'(nd_m), 64'd1);
      check({tag, " result"}, {ghi_m, glo_m}, {ehi, elo});
      check({tag, " div_zero"}, 64'(nz_m), 64'(edz));
      check({tag, " fast latency"}, 64'(lat_f), op[1] ? 64'd34 : 64'd3);
      check({tag, " fast result"}, {ghi_f, glo_f}, {ehi, elo});
      check({tag, " fast done/dz"}, {32'(nd_f), 32'(nz_f)}, {32'd1, 32'(edz)});
      exp_hi_m = ehi; exp_lo_m = elo; exp_hi_f = ehi; exp_lo_f = elo;
   endtask

   initial begin
      int nd;
      logic [1:0] rop;
      logic [W-1:0] ra, rb;
      reset = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
      exp_hi_m = '0; exp_lo_m = '0; exp_hi_f = '0; exp_lo_f = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset outputs", {hi_m, lo_m}, 64'd0);
      check("reset flags", {busy_m, done_m, dz_m, busy_f, done_f, dz_f}, 64'd0);
      reset = 1'b0;

      run_op(2'd0, 32'hFFFF_FFFD, 32'd5, "mult -3*5");
      run_op(2'd1, 32'hFFFF_FFFF, 32'd2, "multu");
      run_op(2'd3, 32'd100, 32'd7, "divu 100/7");
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div -7/2");
      run_op(2'd2, 32'h1234_5678, 32'd0, "div by zero");
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
      run_op(2'd2, 32'h8765_4321, 32'd0, "div neg by zero");

      // Flush mid-divide: unit goes idle, no done, outputs keep prior result.
      @(negedge clk);
      op_i = 2'd3; a_i = 32'd1000; b_i = 32'd3; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush_i = 1'b1;
      @(posedge clk);
      #1 flush_i = 1'b0;
      check("flush busy", 64'(busy_m), 64'd0);
      check("flush done", 64'(done_m), 64'd0);
      check("flush hold", {hi_m, lo_m}, {exp_hi_m, exp_lo_m});
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (done_m || dz_m || done_f) nd++;
      end
      check("flush no done", 64'(nd), 64'd0);
      run_op(2'd3, 32'd1000, 32'd3, "after flush");

      // Start while busy is ignored by the iterative unit.
      @(negedge clk);
      op_i = 2'd1; a_i = 32'd3; b_i = 32'd4; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (4) @(posedge clk);
      #1 begin start_i = 1'b1; op_i = 2'd3; a_i = 32'd100; b_i = 32'd7; end
      @(posedge clk);
      #1 start_i = 1'b0;
      nd = 0;
      for (int c = 6; c <= 45; c++) begin
         @(posedge clk);
         #1;
         if (done_m) begin
            nd++;
            check("busy-start latency", 64'(c), 64'd34);
            check("busy-start result", {hi_m, lo_m}, {32'd0, 32'd12});
         end
      end
      check("busy-start done count", 64'(nd), 64'd1);
      exp_hi_m = 32'd0; exp_lo_m = 32'd12; exp_hi_f = 32'd2; exp_lo_f = 32'd14;

      // Reset in the middle of an operation.
      @(negedge clk);
      op_i = 2'd0; a_i = 32'd77; b_i = 32'd9; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("mid reset", {busy_m, done_m, hi_m, lo_m}, 64'd0);
      exp_hi_m = '0; exp_lo_m = '0; exp_hi_f = '0; exp_lo_f = '0;
      nd = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (done_m) nd++;
      end
      check("mid reset no done", 64'(nd), 64'd0);

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 15));
            3: ra = 32'($urandom_range(0, 255));
            default: ;
         endcase
         run_op(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
